// File: rtl/run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and default parameter values for the run controller.
//   state_t  : controller FSM states
//   status_t : result code of the last run (OK / TIMEOUT / ABORT)
//   CW_DEF, RST_CYC_DEF : default cycle-counter width and reset-hold length
// ---------------------------------------------------------------------------
package run_ctrl_pkg;

    localparam int CW_DEF      = 16;
    localparam int RST_CYC_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_REQ    = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_TIMEOUT = 2'd1,
        STAT_ABORT   = 2'd2
    } status_t;

endpackage

// File: rtl/run_ctrl_cyc_counter.sv
// ---------------------------------------------------------------------------
// cyc_counter
// Saturating CW-bit counter of RUN cycles with a terminal-match compare.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous clear to zero (has priority over enable)
//   i_enable       : advance by one (holds at all-ones once reached)
//   i_max          : terminal value; zero disables the match
//   o_count        : current count
//   o_match        : the value the counter would take on this edge equals
//                    i_max (and i_max is non-zero)
// ---------------------------------------------------------------------------
module cyc_counter
    import run_ctrl_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_enable,
    input  logic [CW-1:0] i_max,
    output logic [CW-1:0] o_count,
    output logic          o_match
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_next;
    logic          w_sat;

    // The match looks at the incremented value so the FSM can leave RUN in
    // the same cycle the count reaches the limit.
    assign w_sat   = &r_count;
    assign w_next  = w_sat ? r_count : (r_count + ONE);
    assign o_match = (i_max != '0) && (w_next == i_max);
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl
// Launches a processor core: holds it in reset, strobes a request, then
// counts RUN cycles until the core reports done, a timeout expires, or the
// host aborts. Reports the result and cycle count of the last run.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : launch request (accepted only in IDLE)
//   i_abort          : cancel (honoured in RESET, REQ and RUN)
//   i_max_cycles     : RUN-cycle timeout limit, 0 = no timeout
//   i_cpu_done       : core finished flag
//   o_cpu_reset      : active-high reset to the core
//   o_cpu_req        : one-cycle request strobe to the core
//   o_busy           : high in every state except IDLE
//   o_finished       : one-cycle pulse when a run ends
//   o_status         : 0 OK, 1 TIMEOUT, 2 ABORT
//   o_cycle_count    : RUN cycles consumed by the last/current run
// All outputs are decoded from registers only.
// ---------------------------------------------------------------------------
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int RST_CYC = RST_CYC_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [CW-1:0] i_max_cycles,
    input  logic          i_cpu_done,
    output logic          o_cpu_reset,
    output logic          o_cpu_req,
    output logic          o_busy,
    output logic          o_finished,
    output logic [1:0]    o_status,
    output logic [CW-1:0] o_cycle_count
);

    localparam logic [3:0] RST_LAST = 4'(RST_CYC - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_rst_cnt;
    logic [3:0] w_rst_cnt_next;
    status_t    r_status;
    status_t    w_status_next;
    logic       w_cnt_clear;
    logic       w_cnt_en;
    logic       w_match;

    cyc_counter #(
        .CW (CW)
    ) u_cyc_counter (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .i_max    (i_max_cycles),
        .o_count  (o_cycle_count),
        .o_match  (w_match)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_rst_cnt <= 4'd0;
            r_status  <= STAT_OK;
        end else begin
            r_state   <= w_state_next;
            r_rst_cnt <= w_rst_cnt_next;
            r_status  <= w_status_next;
        end
    end

    // Abort is checked first in every busy state so it outranks done and
    // timeout; in RUN it also suppresses the increment, freezing the count.
    // Done is checked before the timeout match so a coincident done wins.
    always_comb begin
        w_state_next   = r_state;
        w_rst_cnt_next = r_rst_cnt;
        w_status_next  = r_status;
        w_cnt_clear    = 1'b0;
        w_cnt_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next   = S_RESET;
                    w_rst_cnt_next = 4'd0;
                    w_status_next  = STAT_OK;
                    w_cnt_clear    = 1'b1;
                end
            end
            S_RESET: begin
                if (i_abort) begin
                    w_state_next  = S_FINISH;
                    w_status_next = STAT_ABORT;
                end else if (r_rst_cnt == RST_LAST) begin
                    w_state_next   = S_REQ;
                    w_rst_cnt_next = 4'd0;
                end else begin
                    w_rst_cnt_next = r_rst_cnt + 4'd1;
                end
            end
            S_REQ: begin
                if (i_abort) begin
                    w_state_next  = S_FINISH;
                    w_status_next = STAT_ABORT;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_next  = S_FINISH;
                    w_status_next = STAT_ABORT;
                end else begin
                    w_cnt_en = 1'b1;
                    if (i_cpu_done) begin
                        w_state_next  = S_FINISH;
                        w_status_next = STAT_OK;
                    end else if (w_match) begin
                        w_state_next  = S_FINISH;
                        w_status_next = STAT_TIMEOUT;
                    end
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_cpu_reset = (r_state == S_IDLE) || (r_state == S_RESET);
    assign o_cpu_req   = (r_state == S_REQ);
    assign o_busy      = (r_state != S_IDLE);
    assign o_finished  = (r_state == S_FINISH);
    assign o_status    = r_status;

endmodule

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl
// Directed bench for run_ctrl. The main instance uses CW=16, RST_CYC=2; a
// second CW=4 instance exercises counter saturation.
// Outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_run_ctrl;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        abort;
    logic [15:0] maxCycles;
    logic        cpuDone;
    logic        cpuReset;
    logic        cpuReq;
    logic        busy;
    logic        finished;
    logic [1:0]  status;
    logic [15:0] cycleCount;

    logic        start4;
    logic        abort4;
    logic [3:0]  maxCycles4;
    logic        cpuDone4;
    logic        cpuReset4;
    logic        cpuReq4;
    logic        busy4;
    logic        finished4;
    logic [1:0]  status4;
    logic [3:0]  cycleCount4;

    int nCompared;
    int nMismatched;

    run_ctrl #(
        .CW      (16),
        .RST_CYC (2)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_start       (start),
        .i_abort       (abort),
        .i_max_cycles  (maxCycles),
        .i_cpu_done    (cpuDone),
        .o_cpu_reset   (cpuReset),
        .o_cpu_req     (cpuReq),
        .o_busy        (busy),
        .o_finished    (finished),
        .o_status      (status),
        .o_cycle_count (cycleCount)
    );

    run_ctrl #(
        .CW      (4),
        .RST_CYC (2)
    ) u_dut4 (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_start       (start4),
        .i_abort       (abort4),
        .i_max_cycles  (maxCycles4),
        .i_cpu_done    (cpuDone4),
        .o_cpu_reset   (cpuReset4),
        .o_cpu_req     (cpuReq4),
        .o_busy        (busy4),
        .o_finished    (finished4),
        .o_status      (status4),
        .o_cycle_count (cycleCount4)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic d,
                                 input logic [15:0] m);
        start     = s;
        abort     = a;
        cpuDone   = d;
        maxCycles = m;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Checks the full output set of the main instance in one call.
    task automatic checkAll(input string tag, input logic eRst, input logic eReq,
                            input logic eBusy, input logic eFin,
                            input logic [1:0] eStat, input logic [15:0] eCnt);
        checkOutput({tag, ".cpu_reset"},   32'(cpuReset),   32'(eRst));
        checkOutput({tag, ".cpu_req"},     32'(cpuReq),     32'(eReq));
        checkOutput({tag, ".busy"},        32'(busy),       32'(eBusy));
        checkOutput({tag, ".finished"},    32'(finished),   32'(eFin));
        checkOutput({tag, ".status"},      32'(status),     32'(eStat));
        checkOutput({tag, ".cycle_count"}, 32'(cycleCount), 32'(eCnt));
    endtask

    // Pulse start for one edge, then advance through RESET (2) and REQ,
    // leaving the bench in the first RUN cycle.
    task automatic launch(input logic [15:0] m);
        applyStimulus(1'b1, 1'b0, 1'b0, m);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rstN        = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd100);
        start4      = 1'b0;
        abort4      = 1'b0;
        cpuDone4    = 1'b0;
        maxCycles4  = 4'd0;

        tick();
        checkAll("rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        tick();
        rstN = 1'b1;
        tick();
        checkAll("idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);

        $display("[TB] normal run, done in 5th RUN cycle");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd100);
        tick();
        start = 1'b0;
        checkAll("t1.reset1", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        tick();
        checkAll("t1.reset2", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        tick();
        checkAll("t1.req", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'd0);
        tick();
        checkAll("t1.run1", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        tick();
        tick();
        tick();
        tick();
        checkAll("t1.run5", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd4);
        cpuDone = 1'b1;
        tick();
        cpuDone = 1'b0;
        checkAll("t1.finish", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd5);
        tick();
        checkAll("t1.idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd5);

        $display("[TB] timeout at 10");
        launch(16'd10);
        for (int i = 0; i < 9; i++) tick();
        checkAll("t2.run10", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd9);
        tick();
        checkAll("t2.finish", 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'd10);
        tick();
        checkAll("t2.idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 16'd10);

        $display("[TB] done coincides with timeout");
        launch(16'd10);
        for (int i = 0; i < 9; i++) tick();
        cpuDone = 1'b1;
        tick();
        cpuDone = 1'b0;
        checkAll("t3.finish", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd10);
        tick();

        $display("[TB] abort with done in 3rd RUN cycle, stray starts");
        launch(16'd100);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkAll("t4.run2", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'd100);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd100);
        checkAll("t4.finish", 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 16'd2);
        tick();
        start = 1'b0;
        checkAll("t4.idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 16'd2);
        tick();
        checkAll("t4.stay", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 16'd2);

        $display("[TB] abort during RESET");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd100);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd100);
        tick();
        abort = 1'b0;
        checkAll("t5.finish", 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 16'd0);
        tick();

        $display("[TB] saturation on CW=4 instance");
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        checkOutput("t6.run16.count", 32'(cycleCount4), 32'd15);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t6.run20.count", 32'(cycleCount4), 32'd15);
        checkOutput("t6.run20.busy", 32'(busy4), 32'd1);
        cpuDone4 = 1'b1;
        tick();
        cpuDone4 = 1'b0;
        checkOutput("t6.finish.fin", 32'(finished4), 32'd1);
        checkOutput("t6.finish.status", 32'(status4), 32'd0);
        checkOutput("t6.finish.count", 32'(cycleCount4), 32'd15);
        tick();

        $display("[TB] reset mid-run");
        launch(16'd100);
        tick();
        tick();
        checkAll("t7.run3", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd2);
        #2;
        rstN = 1'b0;
        #1;
        checkAll("t7.inreset", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        tick();
        rstN = 1'b1;
        tick();
        checkAll("t7.after", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        launch(16'd100);
        tick();
        tick();
        cpuDone = 1'b1;
        tick();
        cpuDone = 1'b0;
        checkAll("t7.finish", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd3);
        tick();
        checkAll("t7.idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
